u_pipe_add: RTL

- Parametrised, pipelined successor to the 32-bit ripple-carry adder.
- Splits the WIDTH-bit carry chain into STAGES equal slices, one slice per clock. Carry and operands are skewed through pipeline registers.
- Optional subtract mode; valid/ready handshakes on both sides.
- Sits in the datapath wherever a wide add or subtract must close timing at full clock rate.

---
 rtl/u_pipe_add_if.sv | 37 +++
 rtl/u_pipe_add.sv | 110 +++++++++++
 2 files changed

// File: rtl/u_pipe_add_if.sv
// Handshake bundle for u_pipe_add: operands/mode upstream, result downstream.
// Build option U_PIPE_ADD_OVF_EN adds the ovf result bit.
interface u_pipe_add_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             cin1;
    logic             sub;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sout;
    logic             cout;
    logic             out_valid;
    logic             out_ready;
`ifdef U_PIPE_ADD_OVF_EN
    logic             ovf;

    modport master (
        output in1, in2, cin1, sub, in_valid, out_ready,
        input  in_ready, sout, cout, out_valid, ovf
    );
    modport slave (
        input  in1, in2, cin1, sub, in_valid, out_ready,
        output in_ready, sout, cout, out_valid, ovf
    );
`else
    modport master (
        output in1, in2, cin1, sub, in_valid, out_ready,
        input  in_ready, sout, cout, out_valid
    );
    modport slave (
        input  in1, in2, cin1, sub, in_valid, out_ready,
        output in_ready, sout, cout, out_valid
    );
`endif
endinterface

// File: rtl/u_pipe_add.sv
// Pipelined add/subtract: the WIDTH-bit carry chain is cut into STAGES slices, one per clock.
// Define U_PIPE_ADD_OVF_EN to add a registered signed-overflow output (bus.ovf).
module u_pipe_add #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input logic           clk,
    input logic           rst,
    u_pipe_add_if.slave   bus
);
    localparam int unsigned SW   = WIDTH / STAGES;
    localparam int unsigned LAST = STAGES - 1;

    logic              adv;
    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] cy_q, cy_d;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];

    // Whole pipeline moves as one; invalid slots are not squeezed out.
    assign adv          = bus.out_ready | ~vld_q[LAST];
    assign bus.in_ready = adv;
    assign bus.out_valid = vld_q[LAST];
    assign bus.sout     = s_q[LAST];
    assign bus.cout     = cy_q[LAST];

    always_comb begin
        logic [WIDTH-1:0] a_src;
        logic [WIDTH-1:0] b_src;
        logic [WIDTH-1:0] s_src;
        logic             c_src;
        logic             v_src;
        logic [SW:0]      slice;
        int               p;
        a_src = '0;
        b_src = '0;
        s_src = '0;
        c_src = 1'b0;
        v_src = 1'b0;
        slice = '0;
        p     = 0;
        vld_d = '0;
        cy_d  = '0;
        for (int k = 0; k < int'(STAGES); k++) begin
            p = (k == 0) ? 0 : k - 1;
            if (k == 0) begin
                // Subtract is in1 + ~in2 + 1; cin1 is ignored then.
                v_src = bus.in_valid;
                a_src = bus.in1;
                b_src = bus.sub ? ~bus.in2 : bus.in2;
                s_src = '0;
                c_src = bus.sub | bus.cin1;
            end else begin
                v_src = vld_q[p];
                a_src = a_q[p];
                b_src = b_q[p];
                s_src = s_q[p];
                c_src = cy_q[p];
            end
            slice = {1'b0, a_src[k*SW +: SW]} + {1'b0, b_src[k*SW +: SW]} + {{SW{1'b0}}, c_src};
            s_src[k*SW +: SW] = slice[SW-1:0];
            vld_d[k] = v_src;
            cy_d[k]  = slice[SW];
            a_d[k]   = a_src;
            b_d[k]   = b_src;
            s_d[k]   = s_src;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            cy_q  <= '0;
            for (int k = 0; k < int'(STAGES); k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (adv) begin
            vld_q <= vld_d;
            cy_q  <= cy_d;
            for (int k = 0; k < int'(STAGES); k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
        end
    end

`ifdef U_PIPE_ADD_OVF_EN
    logic ovf_q, ovf_d;

    // Carry into the MSB is recovered from the MSB's operand and sum bits.
    assign ovf_d   = (a_d[LAST][WIDTH-1] ^ b_d[LAST][WIDTH-1] ^ s_d[LAST][WIDTH-1]) ^ cy_d[LAST];
    assign bus.ovf = ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= ovf_d;
        end
    end
`endif

endmodule
